uart_hex_sender: RTL and testbench

UART_HEX_SENDER -- requirements
Module: uart_hex_sender

---
 rtl/uart_hex_sender.sv | 149 ++++++++++++++
 tb/tb_uart_hex_sender.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_sender.sv
// rtl/uart_hex_sender.sv - prints a word as uppercase hex (or "ERR") plus CR LF over an 8N1 UART
module uart_hex_sender #(
    parameter int CLOCK_RATE  = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DIGIT_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready_in,
    input  logic [4*DIGIT_COUNT-1:0] data_in,
    input  logic                     error_in,
    output logic                     busy,
    output logic                     RsTx
);

    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int N_MAX        = (DIGIT_COUNT + 2 > 5) ? DIGIT_COUNT + 2 : 5;
    localparam int IW           = $clog2(N_MAX);
    localparam int DW           = 4 * DIGIT_COUNT;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [IW-1:0]   char_idx, char_idx_n;
    logic [DW-1:0]   data_q, data_n;
    logic            err_q, err_n;
    logic            tx_q, tx_n;

    logic [DW-1:0]   shifted;
    logic [3:0]      nibble;
    logic [7:0]      char_byte;
    logic            last_char;
    logic            cnt_done;

    assign RsTx = tx_q;
    assign busy = (state != IDLE);

    // Current character is a pure function of the character index and captured request
    always_comb begin
        shifted   = data_q << {char_idx, 2'b00};
        nibble    = shifted[DW-1 -: 4];
        char_byte = 8'h0A;
        if (err_q) begin
            if (char_idx == IW'(0))
                char_byte = 8'h45;
            else if (char_idx == IW'(1) || char_idx == IW'(2))
                char_byte = 8'h52;
            else if (char_idx == IW'(3))
                char_byte = 8'h0D;
        end else if (char_idx < IW'(DIGIT_COUNT)) begin
            char_byte = (nibble < 4'd10) ? 8'h30 + {4'h0, nibble} : 8'h37 + {4'h0, nibble};
        end else if (char_idx == IW'(DIGIT_COUNT)) begin
            char_byte = 8'h0D;
        end
        last_char = err_q ? (char_idx == IW'(4)) : (char_idx == IW'(DIGIT_COUNT + 1));
        cnt_done  = (clk_cnt == CNT_LAST);
    end

    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        char_idx_n = char_idx;
        data_n     = data_q;
        err_n      = err_q;
        tx_n       = tx_q;
        case (state)
            IDLE: begin
                if (ready_in) begin
                    state_n    = START;
                    clk_cnt_n  = '0;
                    bit_idx_n  = '0;
                    char_idx_n = '0;
                    data_n     = data_in;
                    err_n      = error_in;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                if (cnt_done) begin
                    state_n   = DATA;
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    tx_n      = char_byte[0];
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt_done) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = char_byte[bit_idx + 3'd1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt_done) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    if (last_char) begin
                        state_n    = IDLE;
                        char_idx_n = '0;
                        tx_n       = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap
                        state_n    = START;
                        char_idx_n = char_idx + IW'(1);
                        tx_n       = 1'b0;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            char_idx <= char_idx_n;
            data_q   <= data_n;
            err_q    <= err_n;
            tx_q     <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_hex_sender.sv
// tb/tb_uart_hex_sender.sv - scoreboard bench for uart_hex_sender with a mid-bit UART monitor
module tb_uart_hex_sender;

    logic        clk;
    logic        reset;
    logic        ready_in;
    logic [15:0] data_in;
    logic        error_in;
    logic        busy;
    logic        RsTx;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    uart_hex_sender #(
        .CLOCK_RATE (16),
        .BAUD_RATE  (1),
        .DIGIT_COUNT(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ready_in(ready_in),
        .data_in (data_in),
        .error_in(error_in),
        .busy    (busy),
        .RsTx    (RsTx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input logic [47:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.b    = bytes[8*(n-1-i) +: 8];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; the following posedge accepts the request
    task automatic start_req(input logic [15:0] d, input logic e);
        ready_in = 1'b1;
        data_in  = d;
        error_in = e;
        @(negedge clk);
        ready_in = 1'b0;
    endtask

    task automatic wait_idle(input int pulse_at, input logic [15:0] pd, output int c);
        c = 0;
        while (busy && c < 2000) begin
            c++;
            ready_in = (c == pulse_at);
            if (c == pulse_at)
                data_in = pd;
            @(negedge clk);
        end
        ready_in = 1'b0;
    endtask

    // UART monitor: start detected at mon_cnt 0, bits sampled mid-period
    bit         mon_active = 0;
    int         mon_cnt    = 0;
    logic [7:0] rx_byte;

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 0;
            mon_cnt    = 0;
        end else if (!mon_active) begin
            if (RsTx == 1'b0) begin
                mon_active = 1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 8) begin
                chk("start_bit", int'(RsTx), 0);
            end else if (mon_cnt >= 24 && mon_cnt <= 136 && ((mon_cnt - 24) % 16) == 0) begin
                rx_byte[(mon_cnt - 24) / 16] = RsTx;
            end else if (mon_cnt == 152) begin
                chk("stop_bit", int'(RsTx), 1);
            end else if (mon_cnt == 160) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_char", int'(rx_byte), -1);
                    mon_active = (RsTx == 1'b0);
                    mon_cnt    = 0;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("char_byte", int'(rx_byte), int'(e.b));
                    if (e.last) begin
                        chk("idle_after_frame", int'(RsTx), 1);
                    end else begin
                        chk("char_gap", int'(RsTx), 0);
                    end
                    mon_active = (RsTx == 1'b0);
                    mon_cnt    = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int busy_hi;
        reset    = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        error_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rstx", int'(RsTx), 1);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Data word 1A3F
        push_bytes(48'h31_41_33_46_0D_0A, 6);
        start_req(16'h1A3F, 1'b0);
        chk("accept_busy", int'(busy), 1);
        wait_idle(0, 16'h0, c);
        chk("busy_1a3f", c, 960);
        repeat (5) @(negedge clk);

        // Error message, data ignored
        push_bytes(48'h00_45_52_52_0D_0A, 5);
        start_req(16'hFFFF, 1'b1);
        wait_idle(0, 16'h0, c);
        chk("busy_err", c, 800);
        repeat (5) @(negedge clk);

        // Back-to-back frames with a 1-cycle gap
        push_bytes(48'h30_30_30_30_0D_0A, 6);
        start_req(16'h0000, 1'b0);
        wait_idle(0, 16'h0, c);
        chk("busy_0000", c, 960);
        chk("idle_cycle_rstx", int'(RsTx), 1);
        push_bytes(48'h39_42_30_43_0D_0A, 6);
        start_req(16'h9B0C, 1'b0);
        chk("gap_accept", int'(busy), 1);
        wait_idle(0, 16'h0, c);
        chk("busy_9b0c", c, 960);
        repeat (5) @(negedge clk);

        // Request during an active frame is ignored
        push_bytes(48'h35_45_37_44_0D_0A, 6);
        start_req(16'h5E7D, 1'b0);
        wait_idle(100, 16'hAAAA, c);
        chk("busy_5e7d", c, 960);
        busy_hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy)
                busy_hi++;
            @(negedge clk);
        end
        chk("no_second_frame", busy_hi, 0);

        // Reset during data bits of the second character
        push_bytes(48'h43_30_44_45_0D_0A, 6);
        start_req(16'hC0DE, 1'b0);
        repeat (200) @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_rstx", int'(RsTx), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("held_rstx", int'(RsTx), 1);
        reset = 1'b1;
        @(negedge clk);
        push_bytes(48'h30_30_30_31_0D_0A, 6);
        start_req(16'h0001, 1'b0);
        wait_idle(0, 16'h0, c);
        chk("busy_0001", c, 960);

        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("final_rstx", int'(RsTx), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
